// File: rtl/exec_unit.sv
// Accumulator execute stage paired with an external fetch unit.
// Two-word jumps are resolved by a small EXEC/TARGET/SKIP/HALT FSM.
module exec_unit #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [15:0]      opcode,
    output logic             BR,
    output logic [15:0]      acc,
    output logic             zf,
    output logic             cf,
    output logic [OUT_W-1:0] io_out,
    output logic             io_valid,
    output logic             halted
);

    localparam logic [1:0] S_EXEC   = 2'd0;
    localparam logic [1:0] S_TARGET = 2'd1;
    localparam logic [1:0] S_SKIP   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ADD  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [15:0] rf [4];
    logic [3:0]  op;
    logic [15:0] imm;
    logic [1:0]  r;
    logic [15:0] acc_n;
    logic        zf_n;
    logic        cf_n;
    logic        upd_z;
    logic        rf_we;
    logic        out_we;
    logic        io_valid_q;
    logic [16:0] sum_imm;
    logic [16:0] sum_reg;
    logic [16:0] diff_imm;
    logic        unused_bits;

    assign op  = opcode[15:12];
    assign imm = {8'd0, opcode[7:0]};
    assign r   = opcode[1:0];

    assign unused_bits = &{1'b0, opcode[11:8]};

    // Bit 16 carries the carry-out for sums and the borrow for the difference.
    assign sum_imm  = {1'b0, acc} + {1'b0, imm};
    assign sum_reg  = {1'b0, acc} + {1'b0, rf[r]};
    assign diff_imm = {1'b0, acc} - {1'b0, imm};

    assign BR       = en && !rst && (state == S_TARGET);
    assign io_valid = io_valid_q && en;
    assign halted   = (state == S_HALT);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        zf_n    = zf;
        cf_n    = cf;
        upd_z   = 1'b0;
        rf_we   = 1'b0;
        out_we  = 1'b0;
        unique case (1'b1)
            (state == S_EXEC): begin
                case (op)
                    OP_LDI: begin
                        acc_n = imm;
                        upd_z = 1'b1;
                    end
                    OP_ADDI: begin
                        {cf_n, acc_n} = sum_imm;
                        upd_z = 1'b1;
                    end
                    OP_SUBI: begin
                        {cf_n, acc_n} = diff_imm;
                        upd_z = 1'b1;
                    end
                    OP_ANDI: begin
                        acc_n = acc & imm;
                        upd_z = 1'b1;
                    end
                    OP_ST: rf_we = 1'b1;
                    OP_LD: begin
                        acc_n = rf[r];
                        upd_z = 1'b1;
                    end
                    OP_ADD: begin
                        {cf_n, acc_n} = sum_reg;
                        upd_z = 1'b1;
                    end
                    OP_JMP:  state_n = S_TARGET;
                    OP_JZ:   state_n = zf ? S_TARGET : S_SKIP;
                    OP_JNZ:  state_n = zf ? S_SKIP : S_TARGET;
                    OP_OUT:  out_we  = 1'b1;
                    OP_HALT: state_n = S_HALT;
                    default: ;
                endcase
                if (upd_z) zf_n = (acc_n == 16'd0);
            end
            (state == S_TARGET),
            (state == S_SKIP): state_n = S_EXEC;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EXEC;
            acc        <= '0;
            zf         <= 1'b1;
            cf         <= 1'b0;
            io_out     <= '0;
            io_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (en) begin
            state      <= state_n;
            acc        <= acc_n;
            zf         <= zf_n;
            cf         <= cf_n;
            io_valid_q <= out_we;
            if (rf_we) rf[r] <= acc;
            if (out_we) io_out <= acc[OUT_W-1:0];
        end else begin
            io_valid_q <= 1'b0;
        end
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: OUT_W, default 8, width of the io_out port (1..16); io_out takes acc[OUT_W-1:0].
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  same enable driven to the fetch unit; low = fetch stalled, exec_unit holds all state.
REQ-005 opcode  input  16  fetch unit's registered instruction word; new word each enabled cycle.
REQ-006 BR  output  1  branch request to fetch unit; when high, fetch loads PC with the current opcode word.
REQ-007 acc  output  16  accumulator.
REQ-008 zf  output  1  zero flag; cf  output  1  carry/borrow flag.
REQ-009 io_out  output  OUT_W  output latch; io_valid  output  1  one-cycle strobe on io_out update.
REQ-010 halted  output  1  high while in HALT state.

Function
REQ-011 Decode field: op = opcode[15:12], imm = opcode[7:0] zero-extended to 16 bits, r = opcode[1:0] (4-entry x16 register file).
REQ-012 FSM states: EXEC, TARGET, SKIP, HALT; reset state EXEC.
REQ-013 EXEC executes opcode once per cycle when en=1: 0 NOP; 1 LDI acc<=imm; 2 ADDI acc<=acc+imm; 3 SUBI acc<=acc-imm; 4 ANDI acc<=acc&imm; 5 ST rf[r]<=acc; 6 LD acc<=rf[r]; 7 ADD acc<=acc+rf[r]; 8 JMP; 9 JZ; A JNZ; B OUT; F HALT; C,D,E NOP.
REQ-014 Arithmetic modulo 2^16; cf = carry-out for ADDI/ADD, borrow for SUBI (1 when acc<imm); cf unchanged by other ops.
REQ-015 zf = (new acc == 0), updated by LDI/ADDI/SUBI/ANDI/LD/ADD only; ST, OUT, jumps leave flags unchanged.
REQ-016 Jumps are two-word: word after JMP/JZ/JNZ is the 16-bit target.
REQ-017 JMP, JZ with zf=1, JNZ with zf=0: next state TARGET; otherwise next state SKIP; zf sampled at the jump's execute cycle.
REQ-018 TARGET: BR=1 combinationally for that whole cycle (opcode then equals target word); no architectural update; next state EXEC.
REQ-019 SKIP: BR=0; word discarded, no update; next state EXEC.
REQ-020 BR is high only in TARGET with en=1 and rst=0; BR=0 in all other states, during rst, and whenever en=0.
REQ-021 Branch latency: instruction at the target address is executed 2 enabled cycles after the jump opcode is presented.
REQ-022 OUT: io_out<=acc[OUT_W-1:0], io_valid=1 for the following cycle only; back-to-back OUTs give consecutive strobes.
REQ-023 HALT: halted=1 next cycle; opcode ignored until rst; BR=0; acc, flags, rf, io_out frozen.
REQ-024 en=0: state, acc, flags, rf, io_out held; io_valid forced 0; resumes with same state when en returns high (TARGET held across stall still drives BR on resume).
REQ-025 Jump word as the last word before rst: rst wins, no BR issued.

Reset
REQ-026 rst=1 at posedge: state<=EXEC, acc<=0, zf<=1, cf<=0, rf[0..3]<=0, io_out<=0, io_valid<=0, halted<=0; opcode ignored in the rst cycle.
REQ-027 rst overrides en; rst mid-TARGET/SKIP aborts the jump; first opcode after rst deasserts is executed in EXEC.

Verification
REQ-028 LDI 0x05, ADDI 0xFB -> acc=0x0100, cf=0, zf=0; SUBI 0x01 twice from acc=0x0001 -> acc=0x0000 zf=1, then acc=0xFFFF cf=1.
REQ-029 LDI 0x2A, ST r2, LDI 0, LD r2, OUT -> acc=0x002A, io_out=0x2A, io_valid high exactly one cycle.
REQ-030 LDI 0 then JZ, word 0x0040 -> BR=1 exactly in the cycle opcode=0x0040; next executed instruction from address 0x40; JNZ in same state -> BR never asserted, target word not executed.
REQ-031 JMP with en dropped low for 3 cycles while in TARGET -> BR low during stall, high one cycle after en returns, acc unchanged.
REQ-032 HALT then LDI 0x11 -> halted=1, acc unchanged; rst pulse -> halted=0, acc=0, zf=1, next LDI 0x11 executes.
REQ-033 rst asserted in TARGET cycle -> BR=0 that cycle, all outputs at reset values next cycle.
